// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: meter state encoding and the
// default counter width, both common with the rate divider.
package pulse_period_meter_pkg;

  // Counter / period width; matches the rate divider load width.
  localparam int unsigned WIDTH_DEFAULT = 28;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_e;

endpackage : pulse_period_meter_pkg

// File: rtl/pulse_period_meter_edge_detect.sv
// Rising-edge detector for the tick stream.
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   pulse_i  - tick stream, synchronous to clk_i
//   rise_c_o - combinational: pulse_i high now, low on the previous cycle
module pulse_period_meter_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulse_i,
  output logic rise_c_o
);

  logic pulse_q;

  // Previous-cycle copy of the pulse, updated in every meter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= pulse_i;
    end
  end

  assign rise_c_o = pulse_i & ~pulse_q;

endmodule : pulse_period_meter_edge_detect

// File: rtl/pulse_period_meter.sv
// Measures the clock-cycle spacing between consecutive rising edges of a tick
// stream and presents each period through a valid/ack handshake.
// Ports:
//   clock      - system clock
//   Clear_b    - asynchronous active-low reset
//   Enable     - measurement enable; low forces IDLE and clears the counter
//   pulse      - tick stream, synchronous to clock
//   ack        - consumer acknowledges the current result
//   ClearFlags - synchronous clear of overflow and missed
//   period     - last measured period in clock cycles
//   valid      - period holds an unacknowledged result
//   measuring  - high while in MEASURE
//   overflow   - sticky: counter saturated without an edge
//   missed     - sticky: a result was overwritten before ack
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             Clear_b,
  input  logic             Enable,
  input  logic             pulse,
  input  logic             ack,
  input  logic             ClearFlags,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             measuring,
  output logic             overflow,
  output logic             missed
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             measuring_q, measuring_d;
  logic             overflow_q, overflow_d;
  logic             missed_q, missed_d;
  logic             rise_c;

  pulse_period_meter_edge_detect u_edge (
    .clk_i    (clock),
    .rst_ni   (Clear_b),
    .pulse_i  (pulse),
    .rise_c_o (rise_c)
  );

  // State and result registers.
  always_ff @(posedge clock or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      measuring_q <= 1'b0;
      overflow_q  <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      measuring_q <= measuring_d;
      overflow_q  <= overflow_d;
      missed_q    <= missed_d;
    end
  end

  // Next-state, counter, handshake and flag logic. Flag clears are applied
  // before the state case so that a same-cycle set overrides them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    missed_d   = missed_q;

    if (valid_q && ack) begin
      valid_d = 1'b0;
    end

    if (ClearFlags) begin
      overflow_d = 1'b0;
      missed_d   = 1'b0;
    end

    if (!Enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (rise_c) begin
            state_d = MEASURE;
            cnt_d   = WIDTH'(1);
          end
        end
        MEASURE: begin
          if (rise_c) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = WIDTH'(1);
            // An ack in the same cycle consumes the old result, so no miss.
            if (valid_q && !ack) begin
              missed_d = 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            overflow_d = 1'b1;
            state_d    = WAIT_FIRST;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    measuring_d = (state_d == MEASURE);
  end

  assign period    = period_q;
  assign valid     = valid_q;
  assign measuring = measuring_q;
  assign overflow  = overflow_q;
  assign missed    = missed_q;

endmodule : pulse_period_meter

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: a full-width instance for the
// handshake/enable/reset scenarios and a 4-bit instance for saturation.
module tb_pulse_period_meter;

  localparam int unsigned W  = 28;
  localparam int unsigned WS = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          Clear_b, Enable, pulse, ack, ClearFlags;
  logic [W-1:0]  period;
  logic          valid, measuring, overflow, missed;

  logic          s_enable, s_pulse, s_ack, s_clear_flags;
  logic [WS-1:0] s_period;
  logic          s_valid, s_measuring, s_overflow, s_missed;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected periods pushed when the closing rise is driven.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_p;

  pulse_period_meter #(.WIDTH(W)) dut (
    .clock      (clock),
    .Clear_b    (Clear_b),
    .Enable     (Enable),
    .pulse      (pulse),
    .ack        (ack),
    .ClearFlags (ClearFlags),
    .period     (period),
    .valid      (valid),
    .measuring  (measuring),
    .overflow   (overflow),
    .missed     (missed)
  );

  pulse_period_meter #(.WIDTH(WS)) dut_small (
    .clock      (clock),
    .Clear_b    (Clear_b),
    .Enable     (s_enable),
    .pulse      (s_pulse),
    .ack        (s_ack),
    .ClearFlags (s_clear_flags),
    .period     (s_period),
    .valid      (s_valid),
    .measuring  (s_measuring),
    .overflow   (s_overflow),
    .missed     (s_missed)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_rise();
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
  endtask

  task automatic s_send_rise();
    s_pulse = 1'b1;
    tick(1);
    s_pulse = 1'b0;
  endtask

  task automatic apply_reset();
    Enable = 1'b0; pulse = 1'b0; ack = 1'b0; ClearFlags = 1'b0;
    s_enable = 1'b0; s_pulse = 1'b0; s_ack = 1'b0; s_clear_flags = 1'b0;
    Clear_b = 1'b0;
    tick(2);
    Clear_b = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    Clear_b = 1'b1; Enable = 1'b0; pulse = 1'b0; ack = 1'b0; ClearFlags = 1'b0;
    s_enable = 1'b0; s_pulse = 1'b0; s_ack = 1'b0; s_clear_flags = 1'b0;
    #2 Clear_b = 1'b0;
    #1;
    n_checks++;
    if ({period, valid, measuring, overflow, missed} !== '0) begin
      n_fail++;
      $display("FAIL reset_main: got period=%0d v=%b m=%b o=%b x=%b want all 0",
               period, valid, measuring, overflow, missed);
    end
    n_checks++;
    if ({s_period, s_valid, s_measuring, s_overflow, s_missed} !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got period=%0d v=%b m=%b o=%b x=%b want all 0",
               s_period, s_valid, s_measuring, s_overflow, s_missed);
    end
    tick(2);
    Clear_b = 1'b1;
    tick(1);
  endtask

  // Divider-style tick train with reload 4 (one-cycle pulse every 5 cycles).
  task automatic test_divider();
    apply_reset();
    Enable = 1'b1; ack = 1'b1;
    tick(2);
    send_rise();
    n_checks++;
    if (measuring !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL div_first: got measuring=%b valid=%b want 1/0", measuring, valid);
    end
    tick(4);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(W'(5));
      send_rise();
      exp_p = exp_q.pop_front();
      n_checks++;
      if (valid !== 1'b1 || period !== exp_p) begin
        n_fail++;
        $display("FAIL div_result[%0d]: got valid=%b period=%0d want 1/%0d", k, valid, period, exp_p);
      end
      tick(1);
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL div_ack[%0d]: got valid=%b want 0", k, valid);
      end
      tick(3);
    end
    n_checks++;
    if (missed !== 1'b0) begin
      n_fail++;
      $display("FAIL div_missed: got %b want 0", missed);
    end
    ack = 1'b0;
  endtask

  task automatic test_missed();
    apply_reset();
    Enable = 1'b1;
    tick(2);
    send_rise();
    tick(6);
    exp_q.push_back(W'(7));
    send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p || missed !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_first: got v=%b p=%0d x=%b want 1/%0d/0", valid, period, missed, exp_p);
    end
    tick(12);
    exp_q.push_back(W'(13));
    send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p || missed !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_overwrite: got v=%b p=%0d x=%b want 1/%0d/1", valid, period, missed, exp_p);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || missed !== 1'b1) begin
      n_fail++;
      $display("FAIL miss_ack: got v=%b x=%b want 0/1", valid, missed);
    end
    ClearFlags = 1'b1;
    tick(1);
    ClearFlags = 1'b0;
    n_checks++;
    if (missed !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_clear: got %b want 0", missed);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    s_enable = 1'b1;
    tick(2);
    s_send_rise();
    tick(14);
    n_checks++;
    if (s_overflow !== 1'b0 || s_measuring !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_early: got o=%b m=%b want 0/1", s_overflow, s_measuring);
    end
    tick(1);
    n_checks++;
    if (s_overflow !== 1'b1 || s_measuring !== 1'b0 || s_valid !== 1'b0 || s_period !== '0) begin
      n_fail++;
      $display("FAIL ovf_sat: got o=%b m=%b v=%b p=%0d want 1/0/0/0",
               s_overflow, s_measuring, s_valid, s_period);
    end
    s_send_rise();
    n_checks++;
    if (s_measuring !== 1'b1 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_rearm: got m=%b v=%b want 1/0", s_measuring, s_valid);
    end
    tick(2);
    exp_q.push_back(W'(3));
    s_send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (s_valid !== 1'b1 || W'(s_period) !== exp_p || s_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_after: got v=%b p=%0d o=%b want 1/%0d/1", s_valid, s_period, s_overflow, exp_p);
    end
    s_clear_flags = 1'b1;
    tick(1);
    s_clear_flags = 1'b0;
    n_checks++;
    if (s_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", s_overflow);
    end
    s_enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    Enable = 1'b1;
    tick(2);
    send_rise();
    tick(3);
    exp_q.push_back(W'(4));
    send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b p=%0d want 1/%0d", valid, period, exp_p);
    end
    tick(5);
    ack = 1'b1;
    exp_q.push_back(W'(6));
    send_rise();
    ack = 1'b0;
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p || missed !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack_rise: got v=%b p=%0d x=%b want 1/%0d/0", valid, period, missed, exp_p);
    end
    tick(1);
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold: got valid=%b want 1", valid);
    end
    // Miss set and flag clear in the same cycle: the set must win.
    tick(1);
    ClearFlags = 1'b1;
    exp_q.push_back(W'(3));
    send_rise();
    ClearFlags = 1'b0;
    exp_p = exp_q.pop_front();
    n_checks++;
    if (missed !== 1'b1 || period !== exp_p) begin
      n_fail++;
      $display("FAIL b2b_set_wins: got x=%b p=%0d want 1/%0d", missed, period, exp_p);
    end
    ClearFlags = 1'b1;
    ack = 1'b1;
    tick(1);
    ClearFlags = 1'b0;
    ack = 1'b0;
    n_checks++;
    if (missed !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_clear: got x=%b v=%b want 0/0", missed, valid);
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    Enable = 1'b1;
    tick(2);
    send_rise();
    tick(3);
    exp_q.push_back(W'(4));
    send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p) begin
      n_fail++;
      $display("FAIL en_first: got v=%b p=%0d want 1/%0d", valid, period, exp_p);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(2);
    Enable = 1'b0;
    tick(3);
    n_checks++;
    if (measuring !== 1'b0 || period !== W'(4)) begin
      n_fail++;
      $display("FAIL en_off: got m=%b p=%0d want 0/4", measuring, period);
    end
    // Rise coincident with re-enable is seen in IDLE and must be ignored.
    Enable = 1'b1;
    send_rise();
    n_checks++;
    if (measuring !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_idle_rise: got m=%b v=%b want 0/0", measuring, valid);
    end
    tick(2);
    send_rise();
    n_checks++;
    if (measuring !== 1'b1 || valid !== 1'b0 || period !== W'(4)) begin
      n_fail++;
      $display("FAIL en_rearm: got m=%b v=%b p=%0d want 1/0/4", measuring, valid, period);
    end
    tick(8);
    exp_q.push_back(W'(9));
    send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p) begin
      n_fail++;
      $display("FAIL en_result: got v=%b p=%0d want 1/%0d", valid, period, exp_p);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    Enable = 1'b1;
    tick(2);
    send_rise();
    tick(4);
    exp_q.push_back(W'(5));
    send_rise();
    tick(2);
    exp_q.push_back(W'(3));
    send_rise();
    exp_p = exp_q.pop_front();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || missed !== 1'b1 || period !== exp_p || measuring !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: got v=%b x=%b p=%0d m=%b want 1/1/%0d/1", valid, missed, period, measuring, exp_p);
    end
    #2 Clear_b = 1'b0;
    #1;
    n_checks++;
    if ({period, valid, measuring, overflow, missed} !== '0) begin
      n_fail++;
      $display("FAIL ar_async: got p=%0d v=%b m=%b o=%b x=%b want all 0",
               period, valid, measuring, overflow, missed);
    end
    @(posedge clock);
    #1;
    Clear_b = 1'b1;
    tick(1);
    send_rise();
    n_checks++;
    if (valid !== 1'b0 || measuring !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_first: got v=%b m=%b want 0/1", valid, measuring);
    end
    tick(5);
    exp_q.push_back(W'(6));
    send_rise();
    exp_p = exp_q.pop_front();
    n_checks++;
    if (valid !== 1'b1 || period !== exp_p) begin
      n_fail++;
      $display("FAIL ar_result: got v=%b p=%0d want 1/%0d", valid, period, exp_p);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divider();
    test_missed();
    test_overflow();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pulse_period_meter
